vpu_seq: RTL and testbench

//  Multi-beat sequencer for the 8-lane x16b VPU datapath. Accepts one vector op

---
 rtl/vpu_pkg.sv | 35 +++
 rtl/vpu_op_decode.sv | 17 +
 rtl/vpu_seq.sv | 145 ++++++++++++++
 tb/tb_vpu_seq.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vpu_pkg.sv
// rtl/vpu_pkg.sv - VPU opcodes, select classes, sequencer states and descriptor type
package vpu_pkg;
  localparam int VREG_AW   = 5;
  localparam int MAX_BEATS = 4;
  localparam int BEAT_W    = $clog2(MAX_BEATS);
  localparam int NUM_OPS   = 19;

  // Opcode value doubles as the SEL_* bit index in vpu_sel.
  typedef enum logic [4:0] {
    VOP_VADD, VOP_VSUB, VOP_VMUL, VOP_VMIN, VOP_VMAX, VOP_VAND, VOP_VOR, VOP_VXOR,
    VOP_VSLL, VOP_VSRL, VOP_VSRA, VOP_VMOV, VOP_VFTL, VOP_VITF, VOP_VSPL,
    VOP_VCGE, VOP_VCLT, VOP_VCEQ, VOP_VCNQ
  } vop_e;

  localparam logic [NUM_OPS-1:0] IS_CMP = 19'h78000;
  localparam logic [NUM_OPS-1:0] IS_VWR = 19'h07fff;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  localparam logic [2:0] ST_EX   = 3'd2;
  localparam logic [2:0] ST_WB   = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef struct packed {
    logic [4:0]         op;
    logic               ifsel;
    logic [VREG_AW-1:0] vs1;
    logic [VREG_AW-1:0] vs2;
    logic [VREG_AW-1:0] vd;
    logic [BEAT_W-1:0]  beats;
    logic [31:0]        mask;
    logic [31:0]        fs;
    logic [31:0]        rs;
  } desc_t;
endpackage

// File: rtl/vpu_op_decode.sv
// rtl/vpu_op_decode.sv - opcode to one-hot VPU select and op class flags
module vpu_op_decode
  import vpu_pkg::*;
(
  input  logic [4:0]         op,
  output logic [NUM_OPS-1:0] sel,
  output logic               is_cmp,
  output logic               writes_vrf,
  output logic               illegal
);
  always_comb begin
    illegal    = (op >= 5'(NUM_OPS));
    sel        = illegal ? '0 : (NUM_OPS'(1) << op);
    is_cmp     = |(sel & IS_CMP);
    writes_vrf = |(sel & IS_VWR);
  end
endmodule

// File: rtl/vpu_seq.sv
// rtl/vpu_seq.sv - multi-beat vector op sequencer: VRF read, VPU drive, VRF writeback
module vpu_seq
  import vpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [4:0]   req_op,
  input  logic         req_ifsel,
  input  logic [4:0]   req_vs1,
  input  logic [4:0]   req_vs2,
  input  logic [4:0]   req_vd,
  input  logic [1:0]   req_beats,
  input  logic [31:0]  req_mask,
  input  logic [31:0]  req_fs,
  input  logic [31:0]  req_rs,
  output logic [4:0]   vrf_ra1,
  output logic [4:0]   vrf_ra2,
  input  logic [127:0] vrf_rd1,
  input  logic [127:0] vrf_rd2,
  output logic         vrf_we,
  output logic [4:0]   vrf_wa,
  output logic [127:0] vrf_wd,
  output logic         vpu_vec_en,
  output logic         vpu_ifsel,
  output logic [18:0]  vpu_sel,
  output logic [127:0] vpu_vs1,
  output logic [127:0] vpu_vs2,
  output logic [31:0]  vpu_fs,
  output logic [31:0]  vpu_rs,
  output logic [31:0]  vpu_mask,
  input  logic [127:0] vpu_vd,
  input  logic [31:0]  vpu_rd,
  input  logic [31:0]  vpu_fd,
  output logic         done_valid,
  output logic [31:0]  done_rd,
  output logic [31:0]  done_fd,
  output logic         done_err
);
  logic [2:0]         state_q, state_d;
  desc_t              desc_q;
  logic [BEAT_W-1:0]  beat_q;
  logic [31:0]        acc_q;
  logic [127:0]       cap_vd_q;
  logic [31:0]        cap_rd_q, cap_fd_q;
  logic [31:0]        done_rd_q, done_fd_q;
  logic               done_err_q;

  logic [4:0]         dec_op;
  logic [NUM_OPS-1:0] dec_sel;
  logic               dec_cmp, dec_wr, dec_ill;
  logic               accept, in_rd, in_ex, in_wb, last_beat;

  // In IDLE the decoder looks at the incoming opcode so illegal ops can skip straight to DONE.
  assign dec_op = (state_q == ST_IDLE) ? req_op : desc_q.op;

  vpu_op_decode u_decode (
    .op         (dec_op),
    .sel        (dec_sel),
    .is_cmp     (dec_cmp),
    .writes_vrf (dec_wr),
    .illegal    (dec_ill)
  );

  assign req_ready = (state_q == ST_IDLE) && !flush;
  assign accept    = req_valid && req_ready;
  assign in_rd     = (state_q == ST_RD);
  assign in_ex     = (state_q == ST_EX);
  assign in_wb     = (state_q == ST_WB);
  assign last_beat = (beat_q == desc_q.beats);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = dec_ill ? ST_DONE : ST_RD;
      ST_RD:   state_d = ST_EX;
      ST_EX:   state_d = ST_WB;
      ST_WB:   state_d = last_beat ? ST_DONE : ST_RD;
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      desc_q     <= '0;
      beat_q     <= '0;
      acc_q      <= '0;
      cap_vd_q   <= '0;
      cap_rd_q   <= '0;
      cap_fd_q   <= '0;
      done_rd_q  <= '0;
      done_fd_q  <= '0;
      done_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        desc_q <= '{op: req_op, ifsel: req_ifsel, vs1: req_vs1, vs2: req_vs2, vd: req_vd,
                    beats: req_beats, mask: req_mask, fs: req_fs, rs: req_rs};
        beat_q     <= '0;
        acc_q      <= '0;
        done_rd_q  <= '0;
        done_fd_q  <= '0;
        done_err_q <= dec_ill;
      end
      if (in_ex) begin
        cap_vd_q <= vpu_vd;
        cap_rd_q <= vpu_rd;
        cap_fd_q <= vpu_fd;
        if (dec_cmp) acc_q[{beat_q, 3'b000} +: 8] <= vpu_rd[7:0];
      end
      if (in_wb && !flush) begin
        if (last_beat) begin
          done_rd_q <= dec_cmp ? acc_q : cap_rd_q;
          done_fd_q <= cap_fd_q;
        end else begin
          beat_q <= beat_q + 1'b1;
        end
      end
    end
  end

  assign vrf_ra1    = in_rd ? desc_q.vs1 + VREG_AW'(beat_q) : '0;
  assign vrf_ra2    = in_rd ? desc_q.vs2 + VREG_AW'(beat_q) : '0;
  assign vrf_we     = in_wb && dec_wr && !flush && !rst;
  assign vrf_wa     = in_wb ? desc_q.vd + VREG_AW'(beat_q) : '0;
  assign vrf_wd     = in_wb ? cap_vd_q : '0;

  assign vpu_vec_en = in_ex;
  assign vpu_ifsel  = in_ex && desc_q.ifsel;
  assign vpu_sel    = in_ex ? dec_sel : '0;
  assign vpu_vs1    = in_ex ? vrf_rd1 : '0;
  assign vpu_vs2    = in_ex ? vrf_rd2 : '0;
  assign vpu_fs     = in_ex ? desc_q.fs : '0;
  assign vpu_rs     = in_ex ? desc_q.rs : '0;
  assign vpu_mask   = in_ex ? {24'h0, desc_q.mask[{beat_q, 3'b000} +: 8]} : '0;

  assign done_valid = (state_q == ST_DONE) && !flush && !rst;
  assign done_rd    = done_rd_q;
  assign done_fd    = done_fd_q;
  assign done_err   = done_err_q;
endmodule

// File: tb/tb_vpu_seq.sv
// tb/tb_vpu_seq.sv - scoreboard bench for vpu_seq with VRF and VPU stubs
module tb_vpu_seq;
  import vpu_pkg::*;

  logic         clk, rst, flush, req_valid, req_ready, req_ifsel;
  logic [4:0]   req_op, req_vs1, req_vs2, req_vd;
  logic [1:0]   req_beats;
  logic [31:0]  req_mask, req_fs, req_rs;
  logic [4:0]   vrf_ra1, vrf_ra2, vrf_wa;
  logic [127:0] vrf_rd1, vrf_rd2, vrf_wd;
  logic         vrf_we, vpu_vec_en, vpu_ifsel;
  logic [18:0]  vpu_sel;
  logic [127:0] vpu_vs1, vpu_vs2, vpu_vd;
  logic [31:0]  vpu_fs, vpu_rs, vpu_mask, vpu_rd, vpu_fd;
  logic         done_valid, done_err;
  logic [31:0]  done_rd, done_fd;

  int total = 0;
  int bad = 0;

  typedef struct packed {logic [4:0] wa; logic [127:0] wd;} wr_t;
  typedef struct packed {logic [31:0] rd; logic [31:0] fd; logic err;} dn_t;
  wr_t wr_q[$];
  dn_t dn_q[$];
  wr_t w;
  dn_t d;

  logic [127:0] vrf_mem [32];
  logic [127:0] ref_vrf [32];
  logic         ld_en;
  logic [4:0]   ld_a;
  logic [127:0] ld_d;

  vpu_seq dut (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_ifsel(req_ifsel), .req_vs1(req_vs1), .req_vs2(req_vs2),
    .req_vd(req_vd), .req_beats(req_beats), .req_mask(req_mask), .req_fs(req_fs),
    .req_rs(req_rs), .vrf_ra1(vrf_ra1), .vrf_ra2(vrf_ra2), .vrf_rd1(vrf_rd1),
    .vrf_rd2(vrf_rd2), .vrf_we(vrf_we), .vrf_wa(vrf_wa), .vrf_wd(vrf_wd),
    .vpu_vec_en(vpu_vec_en), .vpu_ifsel(vpu_ifsel), .vpu_sel(vpu_sel),
    .vpu_vs1(vpu_vs1), .vpu_vs2(vpu_vs2), .vpu_fs(vpu_fs), .vpu_rs(vpu_rs),
    .vpu_mask(vpu_mask), .vpu_vd(vpu_vd), .vpu_rd(vpu_rd), .vpu_fd(vpu_fd),
    .done_valid(done_valid), .done_rd(done_rd), .done_fd(done_fd), .done_err(done_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lane behaviour of the external VPU; returns {fd, rd, vd}.
  function automatic logic [191:0] vpu_fn(input logic [18:0] sel, input logic [127:0] a,
                                          input logic [127:0] b, input logic [7:0] m,
                                          input logic [31:0] fs, input logic [31:0] rs);
    logic [127:0] vd;
    logic [7:0]   c;
    logic [15:0]  la, lb;
    vd = '0;
    c  = '0;
    for (int i = 0; i < 8; i++) begin
      la = a[16*i +: 16];
      lb = b[16*i +: 16];
      if (m[i]) begin
        if (sel[VOP_VADD]) vd[16*i +: 16] = la + lb;
        if (sel[VOP_VSUB]) vd[16*i +: 16] = la - lb;
        if (sel[VOP_VCGE]) c[i] = (la >= lb);
        if (sel[VOP_VCLT]) c[i] = (la < lb);
        if (sel[VOP_VCEQ]) c[i] = (la == lb);
        if (sel[VOP_VCNQ]) c[i] = (la != lb);
      end
    end
    return {fs ^ b[31:0], (|sel[18:15]) ? {24'h0, c} : ({16'h0, a[15:0]} ^ rs), vd};
  endfunction

  assign {vpu_fd, vpu_rd, vpu_vd} = vpu_fn(vpu_sel, vpu_vs1, vpu_vs2, vpu_mask[7:0], vpu_fs, vpu_rs);

  always @(posedge clk) begin
    vrf_rd1 <= vrf_mem[vrf_ra1];
    vrf_rd2 <= vrf_mem[vrf_ra2];
    if (vrf_we) vrf_mem[vrf_wa] <= vrf_wd;
    if (ld_en) vrf_mem[ld_a] <= ld_d;
  end

  always begin
    @(negedge clk);
    #1;
    if (vrf_we) begin
      total++;
      if (wr_q.size() == 0) begin
        bad++;
        $display("FAIL wr_unexpected got wa=%0d exp no write", vrf_wa);
      end else begin
        w = wr_q.pop_front();
        if ({vrf_wa, vrf_wd} !== {w.wa, w.wd}) begin
          bad++;
          $display("FAIL wr_data got wa=%0d wd=%h exp wa=%0d wd=%h", vrf_wa, vrf_wd, w.wa, w.wd);
        end
      end
    end
    if (done_valid) begin
      total++;
      if (dn_q.size() == 0) begin
        bad++;
        $display("FAIL done_unexpected got rd=%h err=%b exp no done", done_rd, done_err);
      end else begin
        d = dn_q.pop_front();
        if ({done_rd, done_fd, done_err} !== {d.rd, d.fd, d.err}) begin
          bad++;
          $display("FAIL done_data got rd=%h fd=%h err=%b exp rd=%h fd=%h err=%b",
                   done_rd, done_fd, done_err, d.rd, d.fd, d.err);
        end
      end
    end
  end

  task automatic load_reg(input logic [4:0] a, input logic [127:0] v);
    @(negedge clk);
    ld_en = 1'b1; ld_a = a; ld_d = v;
    ref_vrf[a] = v;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic issue(input logic [4:0] op, input logic ifs, input logic [4:0] vs1,
                       input logic [4:0] vs2, input logic [4:0] vd, input int beats,
                       input logic [31:0] mask, input int nwr, input bit want_done);
    logic [191:0] r;
    logic [31:0]  acc, fs, rs;
    logic [18:0]  sel;
    fs = $urandom;
    rs = $urandom;
    req_op = op; req_ifsel = ifs; req_vs1 = vs1; req_vs2 = vs2; req_vd = vd;
    req_beats = 2'(beats); req_mask = mask; req_fs = fs; req_rs = rs; req_valid = 1'b1;
    sel = 19'(1) << op;
    acc = '0;
    r   = '0;
    if (op < 5'd19) begin
      for (int b = 0; b <= beats; b++) begin
        r = vpu_fn(sel, ref_vrf[5'(vs1 + b)], ref_vrf[5'(vs2 + b)], mask[8*b +: 8], fs, rs);
        if (op >= VOP_VCGE) acc[8*b +: 8] = r[135:128];
        else if (b < nwr) begin
          wr_q.push_back('{wa: 5'(vd + b), wd: r[127:0]});
          ref_vrf[5'(vd + b)] = r[127:0];
        end
      end
    end
    if (want_done) begin
      if (op >= 5'd19) dn_q.push_back('{rd: 32'h0, fd: 32'h0, err: 1'b1});
      else if (op >= VOP_VCGE) dn_q.push_back('{rd: acc, fd: r[191:160], err: 1'b0});
      else dn_q.push_back('{rd: r[159:128], fd: r[191:160], err: 1'b0});
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    total++;
    if ({vrf_we, done_valid, done_err, vpu_vec_en, vpu_ifsel, vpu_sel, vrf_ra1, vrf_ra2, vrf_wa} !== '0) begin
      bad++; $display("FAIL reset_ctl got we=%b dv=%b sel=%h ra1=%0d exp all 0", vrf_we, done_valid, vpu_sel, vrf_ra1);
    end
    total++;
    if ({done_rd, done_fd, vpu_mask, vpu_fs, vpu_rs, vrf_wd, vpu_vs1, vpu_vs2} !== '0) begin
      bad++; $display("FAIL reset_data got rd=%h fd=%h mask=%h exp all 0", done_rd, done_fd, vpu_mask);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b exp=1", req_ready); end
    for (int a = 0; a < 32; a++) load_reg(5'(a), {$urandom, $urandom, $urandom, $urandom});
  endtask

  task automatic test_vadd();
    @(negedge clk);
    issue(VOP_VADD, 1'b0, 5'd2, 5'd3, 5'd4, 0, 32'h0000_00ff, 1, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      #1;
      if (k == 1) begin
        total++;
        if ({vrf_ra1, vrf_ra2} !== {5'd2, 5'd3}) begin bad++; $display("FAIL vadd_ra got=%0d,%0d exp=2,3", vrf_ra1, vrf_ra2); end
      end
      if (k == 2) begin
        total++;
        if ({vpu_vec_en, vpu_sel, vpu_mask} !== {1'b1, 19'h1, 32'hff}) begin
          bad++; $display("FAIL vadd_ex got en=%b sel=%h mask=%h exp en=1 sel=1 mask=ff", vpu_vec_en, vpu_sel, vpu_mask);
        end
      end
      total++;
      if ({vrf_we, done_valid} !== {k == 3, k == 4}) begin
        bad++; $display("FAIL vadd_timing k=%0d got we=%b dv=%b exp we=%b dv=%b", k, vrf_we, done_valid, k == 3, k == 4);
      end
    end
  endtask

  task automatic test_vceq();
    logic [127:0] v;
    for (int i = 0; i < 4; i++) begin
      v = {$urandom, $urandom, $urandom, $urandom};
      load_reg(5'(8 + i), v);
      load_reg(5'(12 + i), v);
    end
    @(negedge clk);
    issue(VOP_VCEQ, 1'b1, 5'd8, 5'd12, 5'd20, 3, 32'hffff_ffff, 0, 1'b1);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      #1;
      if (k == 2) begin
        total++;
        if (vpu_ifsel !== 1'b1) begin bad++; $display("FAIL vceq_ifsel got=%b exp=1", vpu_ifsel); end
      end
      total++;
      if ({vrf_we, done_valid} !== {1'b0, k == 13}) begin
        bad++; $display("FAIL vceq_timing k=%0d got we=%b dv=%b exp we=0 dv=%b", k, vrf_we, done_valid, k == 13);
      end
      if (k == 13) begin
        total++;
        if (done_rd !== 32'hffff_ffff) begin bad++; $display("FAIL vceq_acc got=%h exp=ffffffff", done_rd); end
      end
    end
  endtask

  task automatic test_vsub_wrap();
    @(negedge clk);
    issue(VOP_VSUB, 1'b0, 5'd30, 5'd10, 5'd31, 2, 32'h0096_c3f0, 3, 1'b1);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      #1;
      if (k <= 9 && (k - 1) % 3 == 0) begin
        total++;
        if (vrf_ra1 !== 5'(30 + (k - 1) / 3)) begin bad++; $display("FAIL wrap_ra k=%0d got=%0d exp=%0d", k, vrf_ra1, 5'(30 + (k - 1) / 3)); end
      end
      if (k <= 9 && k % 3 == 0) begin
        total++;
        if ({vrf_we, vrf_wa} !== {1'b1, 5'(30 + k / 3)}) begin
          bad++; $display("FAIL wrap_wa k=%0d got we=%b wa=%0d exp we=1 wa=%0d", k, vrf_we, vrf_wa, 5'(30 + k / 3));
        end
      end
      if (k == 5) begin
        total++;
        if (vpu_mask !== 32'h0000_00c3) begin bad++; $display("FAIL wrap_mask got=%h exp=000000c3", vpu_mask); end
      end
      total++;
      if (done_valid !== (k == 10)) begin bad++; $display("FAIL wrap_done k=%0d got=%b exp=%b", k, done_valid, k == 10); end
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    issue(VOP_VADD, 1'b0, 5'd5, 5'd6, 5'd16, 3, 32'hffff_ffff, 1, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      flush = (k == 6);
      #1;
      if (k == 3 || k == 6) begin
        total++;
        if (vrf_we !== (k == 3)) begin bad++; $display("FAIL flush_we k=%0d got=%b exp=%b", k, vrf_we, k == 3); end
      end
      if (k == 7) begin
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b exp=1", req_ready); end
      end
    end
  endtask

  task automatic test_illegal();
    @(negedge clk);
    issue(5'd31, 1'b0, 5'd1, 5'd2, 5'd3, 3, 32'hffff_ffff, 0, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      #1;
      total++;
      if ({vpu_sel, vpu_vec_en, done_valid} !== {19'h0, 1'b0, k == 1}) begin
        bad++; $display("FAIL illegal k=%0d got sel=%h en=%b dv=%b exp sel=0 en=0 dv=%b", k, vpu_sel, vpu_vec_en, done_valid, k == 1);
      end
      if (k == 1) begin
        total++;
        if (done_err !== 1'b1) begin bad++; $display("FAIL illegal_err got=%b exp=1", done_err); end
      end
    end
  endtask

  task automatic test_rst_mid();
    @(negedge clk);
    issue(VOP_VADD, 1'b0, 5'd1, 5'd2, 5'd3, 1, 32'hffff_ffff, 0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      rst = (k == 3);
      #1;
      if (k == 3) begin
        total++;
        if ({vrf_we, done_valid} !== 2'b00) begin bad++; $display("FAIL rst_mid got we=%b dv=%b exp 0 0", vrf_we, done_valid); end
      end
      if (k == 4) begin
        total++;
        if ({req_ready, done_rd, vrf_ra1} !== {1'b1, 32'h0, 5'd0}) begin
          bad++; $display("FAIL rst_after got ready=%b rd=%h ra1=%0d exp 1 0 0", req_ready, done_rd, vrf_ra1);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    issue(VOP_VADD, 1'b0, 5'd2, 5'd3, 5'd6, 1, 32'h0000_ffff, 2, 1'b1);
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k == 1) issue(VOP_VSUB, 1'b0, 5'd6, 5'd2, 5'd7, 0, 32'h0000_005a, 1, 1'b1);
      if (k == 9) req_valid = 1'b0;
      #1;
      total++;
      if ({req_ready, done_valid} !== {k == 8 || k == 13, k == 7 || k == 12}) begin
        bad++; $display("FAIL b2b k=%0d got ready=%b dv=%b exp ready=%b dv=%b", k, req_ready, done_valid, k == 8 || k == 13, k == 7 || k == 12);
      end
      if (k == 9) begin
        total++;
        if ({vrf_ra1, vrf_ra2} !== {5'd6, 5'd2}) begin bad++; $display("FAIL b2b_ra got=%0d,%0d exp=6,2", vrf_ra1, vrf_ra2); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_op = '0; req_ifsel = 1'b0;
    req_vs1 = '0; req_vs2 = '0; req_vd = '0; req_beats = '0; req_mask = '0;
    req_fs = '0; req_rs = '0; ld_en = 1'b0; ld_a = '0; ld_d = '0;
    test_reset();
    test_vadd();
    test_vceq();
    test_vsub_wrap();
    test_flush();
    test_illegal();
    test_rst_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    total++;
    if (wr_q.size() != 0 || dn_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain got wr=%0d done=%0d exp 0 0", wr_q.size(), dn_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
